// File: rtl/prom_7116_arbiter.sv
// Two-port arbiter sharing one MB7116 512x4 PROM: grants a requester, holds address
// and active-low enable for ACCESS_CYCLES, captures data with an ACK pulse, then idles the PROM.
module prom_7116_arbiter #(
  parameter int ADDR_WIDTH        = 9,
  parameter int DATA_WIDTH        = 4,
  parameter int ACCESS_CYCLES     = 3,
  parameter int TURNAROUND_CYCLES = 2,
  parameter int PRIORITY_MODE     = 0
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] A0,
  output logic                  ACK0,
  output logic [DATA_WIDTH-1:0] Q0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] A1,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic                  PROM_nE,
  output logic [ADDR_WIDTH-1:0] PROM_A,
  input  logic [DATA_WIDTH-1:0] PROM_Q,
  output logic                  BUSY
);

  localparam int ACC_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int TURN_W = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam logic [ACC_W-1:0]  ACC_LOAD  = ACC_W'(ACCESS_CYCLES - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_TURN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_cnt_q, acc_cnt_d;
  logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  prom_ne_q, prom_ne_d;
  logic [ADDR_WIDTH-1:0] prom_a_q, prom_a_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] q0_q, q0_d;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic                  grant;

  // last_grant doubles as the current owner while ACCESS is in progress.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    last_grant_d = last_grant_q;
    prom_ne_d    = prom_ne_q;
    prom_a_d     = prom_a_q;
    q0_d         = q0_q;
    q1_d         = q1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    if (PRIORITY_MODE == 0)      grant = !REQ0;
    else if (REQ0 && REQ1)       grant = !last_grant_q;
    else                         grant = !REQ0;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          prom_a_d     = grant ? A1 : A0;
          prom_ne_d    = 1'b0;
          acc_cnt_d    = ACC_LOAD;
          last_grant_d = grant;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (acc_cnt_q != '0) begin
          acc_cnt_d = acc_cnt_q - ACC_W'(1);
        end else begin
          if (last_grant_q) begin
            q1_d   = PROM_Q;
            ack1_d = 1'b1;
          end else begin
            q0_d   = PROM_Q;
            ack0_d = 1'b1;
          end
          prom_ne_d  = 1'b1;
          turn_cnt_d = TURN_LOAD;
          state_d    = S_TURN;
        end
      end
      S_TURN: begin
        if (turn_cnt_q == '0) state_d = S_IDLE;
        else                  turn_cnt_d = turn_cnt_q - TURN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_grant resets to 1 so port 0 wins the first round-robin tie.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      acc_cnt_q    <= '0;
      turn_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      prom_ne_q    <= 1'b1;
      prom_a_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      q0_q         <= '0;
      q1_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      last_grant_q <= last_grant_d;
      prom_ne_q    <= prom_ne_d;
      prom_a_q     <= prom_a_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
    end
  end

  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign Q0      = q0_q;
  assign Q1      = q1_q;
  assign PROM_nE = prom_ne_q;
  assign PROM_A  = prom_a_q;
  assign BUSY    = (state_q != S_IDLE);

endmodule

// File: tb/tb_prom_7116_arbiter.sv
// Bench for prom_7116_arbiter: a fixed-priority and a round-robin instance share stimulus;
// expected ACKs are queued at issue time and checked by an independent monitor.
module tb_prom_7116_arbiter;

  typedef struct {
    int         cyc;
    logic [3:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [8:0] a0, a1;

  logic       d0_ack0, d0_ack1, d0_ne, d0_busy;
  logic [3:0] d0_q0, d0_q1, d0_prom_q;
  logic [8:0] d0_prom_a;
  logic       d1_ack0, d1_ack1, d1_ne, d1_busy;
  logic [3:0] d1_q0, d1_q1, d1_prom_q;
  logic [8:0] d1_prom_a;

  logic [3:0] mem [512];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       sb0a0[$], sb0a1[$], sb1a0[$], sb1a1[$];

  prom_7116_arbiter #(.PRIORITY_MODE(0)) dut0 (
    .CLK(clk), .nRESET(rst_n),
    .REQ0(req0), .A0(a0), .ACK0(d0_ack0), .Q0(d0_q0),
    .REQ1(req1), .A1(a1), .ACK1(d0_ack1), .Q1(d0_q1),
    .PROM_nE(d0_ne), .PROM_A(d0_prom_a), .PROM_Q(d0_prom_q), .BUSY(d0_busy)
  );

  prom_7116_arbiter #(.PRIORITY_MODE(1)) dut1 (
    .CLK(clk), .nRESET(rst_n),
    .REQ0(req0), .A0(a0), .ACK0(d1_ack0), .Q0(d1_q0),
    .REQ1(req1), .A1(a1), .ACK1(d1_ack1), .Q1(d1_q1),
    .PROM_nE(d1_ne), .PROM_A(d1_prom_a), .PROM_Q(d1_prom_q), .BUSY(d1_busy)
  );

  // PROM model drives zero while disabled so a mistimed capture is visible.
  assign d0_prom_q = d0_ne ? 4'h0 : mem[d0_prom_a];
  assign d1_prom_q = d1_ne ? 4'h0 : mem[d1_prom_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input int c, input logic [3:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    case (idx)
      0:       sb0a0.push_back(e);
      1:       sb0a1.push_back(e);
      2:       sb1a0.push_back(e);
      default: sb1a1.push_back(e);
    endcase
  endtask

  task automatic mon_port(input int idx, input logic ack, input logic [3:0] q);
    exp_t e;
    bit   have;
    if (ack !== 1'b1) return;
    have = 1'b0;
    case (idx)
      0:       if (sb0a0.size() > 0) begin e = sb0a0.pop_front(); have = 1'b1; end
      1:       if (sb0a1.size() > 0) begin e = sb0a1.pop_front(); have = 1'b1; end
      2:       if (sb1a0.size() > 0) begin e = sb1a0.pop_front(); have = 1'b1; end
      default: if (sb1a1.size() > 0) begin e = sb1a1.pop_front(); have = 1'b1; end
    endcase
    check($sformatf("ack_expected_p%0d", idx), 32'(have), 32'd1);
    if (have) begin
      check($sformatf("ack_cycle_p%0d", idx), cyc, e.cyc);
      check($sformatf("ack_data_p%0d", idx), 32'(q), 32'(e.data));
    end
  endtask

  // Monitor: index 0/1 = fixed-priority ports 0/1, 2/3 = round-robin ports 0/1.
  always @(negedge clk) begin
    mon_port(0, d0_ack0, d0_q0);
    mon_port(1, d0_ack1, d0_q1);
    mon_port(2, d1_ack0, d1_q0);
    mon_port(3, d1_ack1, d1_q1);
    if (rst_n) check("no_dual_ack", 32'({d0_ack0 & d0_ack1, d1_ack0 & d1_ack1}), 32'd0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string name);
    check({name, "_dut0"}, 32'({d0_ne, d0_prom_a, d0_ack0, d0_ack1, d0_q0, d0_q1, d0_busy}),
          32'({1'b1, 9'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0}));
    check({name, "_dut1"}, 32'({d1_ne, d1_prom_a, d1_ack0, d1_ack1, d1_q0, d1_q1, d1_busy}),
          32'({1'b1, 9'h000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0}));
  endtask

  task automatic chk_ne_busy(input string name, input logic ne, input logic busy);
    check({name, "_dut0"}, 32'({d0_ne, d0_busy}), 32'({ne, busy}));
    check({name, "_dut1"}, 32'({d1_ne, d1_busy}), 32'({ne, busy}));
  endtask

  task automatic chk_addr(input string name, input logic [8:0] a);
    check({name, "_dut0"}, 32'(d0_prom_a), 32'(a));
    check({name, "_dut1"}, 32'(d1_prom_a), 32'(a));
  endtask

  // Port-0 read from IDLE; addr_late is presented one clock after grant.
  task automatic single_read(input logic [8:0] addr, input logic [8:0] addr_late,
                             input logic [3:0] data);
    int e0;
    req0 = 1'b1;
    a0   = addr;
    e0   = cyc + 1;
    push(0, e0 + 3, data);
    push(2, e0 + 3, data);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 1) a0 = addr_late;
      chk_ne_busy("access_ne", 1'b0, 1'b1);
      chk_addr("access_addr", addr);
    end
    step();
    req0 = 1'b0;
    chk_ne_busy("ack_edge_ne", 1'b1, 1'b1);
    step();
    chk_ne_busy("turn_ne", 1'b1, 1'b1);
    step();
    chk_ne_busy("idle_again", 1'b1, 1'b0);
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 512; i++) mem[i] = 4'(i) ^ 4'h5;
    mem[9'h1A5] = 4'hC;
    mem[9'h000] = 4'h3;
    mem[9'h1FF] = 4'h9;
    mem[9'h010] = 4'h6;
    mem[9'h020] = 4'hA;
    mem[9'h055] = 4'hB;

    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    a0    = '0;
    a1    = '0;

    // Reset values, during and after reset with no requests.
    repeat (3) step();
    chk_reset("reset_held");
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk_reset("reset_released");
    end

    // Single read, then address change one clock after grant.
    single_read(9'h1A5, 9'h1A5, 4'hC);
    check("q1_untouched_dut0", 32'(d0_q1), 32'd0);
    check("q1_untouched_dut1", 32'(d1_q1), 32'd0);
    single_read(9'h010, 9'h020, 4'h6);

    // Async reset one clock after grant aborts the access without ACK.
    req0 = 1'b1;
    a0   = 9'h055;
    step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_mid_access");
    step();
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(0, e0 + 3, 4'hB);
    push(2, e0 + 3, 4'hB);
    repeat (3) begin
      step();
      chk_ne_busy("reaccess_ne", 1'b0, 1'b1);
      chk_addr("reaccess_addr", 9'h055);
    end
    step();
    req0 = 1'b0;
    repeat (2) step();
    chk_ne_busy("reaccess_idle", 1'b1, 1'b0);

    // Both ports held: fixed starves port 1, round-robin alternates from port 0.
    rst_n = 1'b0;
    #1 chk_reset("reset_pulse");
    step();
    rst_n = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    a0   = 9'h000;
    a1   = 9'h1FF;
    e0   = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push(0, e0 + 3 + 6 * k, 4'h3);
      if (k % 2 == 0) push(2, e0 + 3 + 6 * k, 4'h3);
      else            push(3, e0 + 3 + 6 * k, 4'h9);
    end
    repeat (22) step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) step();
    check("dut0_q1_never_written", 32'(d0_q1), 32'd0);
    check("sb_empty_d0p0", sb0a0.size(), 32'd0);
    check("sb_empty_d0p1", sb0a1.size(), 32'd0);
    check("sb_empty_d1p0", sb1a0.size(), 32'd0);
    check("sb_empty_d1p1", sb1a1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prom_7116_arbiter.md
# prom_7116_arbiter

Two-port access controller that shares a single MB7116 512x4 bipolar PROM model between two requesters (e.g. the video lookup path and a CPU/debug readback path). It grants one requester at a time, drives the PROM address and active-low enable, waits a programmable number of clocks covering tAA, and captures the 4-bit data into a per-port register with an acknowledge pulse. A guard interval with the enable deasserted covers tDIS before the next owner is served.

## Interface
- ADDR_WIDTH, 9: PROM address width.
- DATA_WIDTH, 4: PROM data width.
- ACCESS_CYCLES, 3: clocks enable is low and address held before data capture; must be at least 1 and cover tAA (45 ns).
- TURNAROUND_CYCLES, 2: clocks enable is high after each access; must be at least 1 and cover tDIS (30 ns).
- PRIORITY_MODE, 0: 0 = fixed priority, port 0 wins; 1 = round-robin.

- CLK  in  1  system clock; all state changes on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- REQ0  in  1  port 0 request level.
- A0  in  ADDR_WIDTH  port 0 address, held stable while REQ0 is high.
- ACK0  out  1  port 0 one-cycle completion pulse.
- Q0  out  DATA_WIDTH  port 0 read data register, held until the next ACK0.
- REQ1, A1, ACK1, Q1: port 1, same definitions.
- PROM_nE  out  1  PROM chip enable, active low.
- PROM_A  out  ADDR_WIDTH  registered PROM address.
- PROM_Q  in  DATA_WIDTH  PROM data output.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, TURN. Counters: acc_cnt and turn_cnt, each wide enough for its parameter. Register last_grant (1 bit).
- IDLE, no REQ: PROM_nE=1; remain.
- IDLE, REQ present: pick grant g. Mode 0: port 0 if REQ0, else port 1. Mode 1: if both requests are present, take the port not equal to last_grant; otherwise take the single requester.
- On that grant edge: PROM_A<=A_g, PROM_nE<=0, acc_cnt<=ACCESS_CYCLES-1, last_grant<=g, go to ACCESS.
- ACCESS: if acc_cnt!=0, decrement. If acc_cnt==0:
  - capture Q_g<=PROM_Q and ACK_g<=1;
  - PROM_nE<=1, turn_cnt<=TURNAROUND_CYCLES-1, go to TURN.
- TURN: if turn_cnt==0, go to IDLE; else decrement. PROM_nE stays 1.
- ACK0 and ACK1 are cleared on every edge where they are not being set; they are never both high.
- The address is latched at grant. Changes to A_g, or REQ_g dropping, during ACCESS are ignored; the access completes and ACK_g still fires.
- A requester that keeps REQ high into IDLE gets a new access using its current address. Requester rule: drop REQ, or present the next address, within TURNAROUND_CYCLES clocks after ACK.
- Q of the non-granted port never changes.
- Reset (asynchronous, also mid-access) forces immediately:
  - state=IDLE, PROM_nE=1, PROM_A=0, ACK0=ACK1=0, Q0=Q1=0, BUSY=0, counters=0;
  - last_grant=1, so port 0 wins the first round-robin tie.
  - No ACK is issued for an aborted access; the requester re-requests.

## Timing
- Grant at edge e0 (REQ sampled high in IDLE). PROM_nE goes low and PROM_A becomes valid after e0.
- PROM_Q is sampled at edge e0+ACCESS_CYCLES. Enable is low and address stable for exactly ACCESS_CYCLES clock periods before sampling.
- ACK_g and the new Q_g are visible from e0+ACCESS_CYCLES to e0+ACCESS_CYCLES+1.
- PROM_nE is high from e0+ACCESS_CYCLES through the end of TURN. IDLE is re-entered at e0+ACCESS_CYCLES+TURNAROUND_CYCLES.
- Earliest next grant is edge e0+ACCESS_CYCLES+TURNAROUND_CYCLES+1. Maximum throughput is one access per ACCESS_CYCLES+TURNAROUND_CYCLES+1 clocks.
- REQ asserted before e0 in IDLE yields ACK ACCESS_CYCLES edges later. A loser under contention waits at most one full access period in round-robin; in fixed mode it waits unboundedly.
- BUSY rises after e0 and falls after e0+ACCESS_CYCLES+TURNAROUND_CYCLES.

## Test plan
- Reset values: hold nRESET low, then release with no requests. Required: PROM_nE=1, PROM_A=0, ACK0=ACK1=0, Q0=Q1=0, BUSY=0 throughout.
- Single read: PROM image has 0x1A5=0xC; REQ0=1, A0=0x1A5, defaults. Required: PROM_A=0x1A5 with PROM_nE low for exactly 3 clocks. ACK0 pulses 1 clock with Q0=0xC. PROM_nE stays high for 2 clocks. ACK1 stays 0 and Q1 unchanged.
- Fixed priority starvation: PRIORITY_MODE=0, REQ0 and REQ1 held high continuously. Required: ACK0 every 6 clocks and ACK1 never.
- Round-robin: PRIORITY_MODE=1, both requests held with A0=0x000, A1=0x1FF. Required: grants alternate 0,1,0,1 starting with port 0; Q0=mem[0x000] and Q1=mem[0x1FF]; ACK spacing is 6 clocks.
- Address change mid-access: change A0 from 0x010 to 0x020 one clock after grant. Required: PROM_A stays 0x010 and Q0=mem[0x010].
- Async reset in ACCESS: pull nRESET low between edges one clock after grant. Required: PROM_nE=1 immediately with no ACK. After release with REQ0 still high, a fresh full 3-clock access completes.
